// File: rtl/tlb_miss_walker.sv
// tlb_miss_walker: Sv39 page-table walker answering TLB misses over a single-beat memory port.
// Define SVADU_EN to enable hardware A/D write-back of the held PTE on UpdateDA.

// state    | meaning
// IDLE     | waiting for TLBMiss (or UpdateDA with SVADU_EN)
// REQ      | PTE load issued at AdrReg for the current level
// WAIT_ACK | waiting for / decoding the load response
// LEAF     | one-cycle TLBWrite of the held PTE
// UPD_REQ  | A/D store of the held PTE (SVADU_EN only)
// FAULT    | one-cycle WalkFault
// ACCERR   | one-cycle WalkAccErr
module tlb_miss_walker #(
  parameter int PA_BITS = 56,
  parameter int VA_BITS = 39
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               TLBMiss,
  input  logic               UpdateDA,
  input  logic               WriteAccess,
  input  logic [VA_BITS-1:0] VAdr,
  input  logic [43:0]        SATP_PPN,
  output logic               MemReq,
  output logic               MemWrite,
  output logic [PA_BITS-1:0] MemAdr,
  output logic [63:0]        MemWData,
  input  logic               MemAck,
  input  logic [63:0]        MemRData,
  input  logic               MemErr,
  output logic               HPTWStall,
  output logic               TLBWrite,
  output logic [63:0]        PTE,
  output logic [1:0]         PageType,
  output logic               WalkFault,
  output logic               WalkAccErr
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT_ACK, LEAF, UPD_REQ, FAULT, ACCERR} state_t;

  state_t             state, state_nxt;
  logic [17:0]        vpn_q;
  logic [1:0]         level_q;
  logic [PA_BITS-1:0] adr_q;
  logic [63:0]        pte_q;
  logic               got_q, err_q;

  logic [63:0] pte_cur;
  logic        err_cur, resp, pte_bad, pte_leaf, misaligned, descend;
  logic [43:0] ppn_cur;
  logic [8:0]  vpn_nxt;
  logic [55:0] root_full, next_full;

  // A response may have been captured in REQ; WAIT_ACK then decodes the held copy.
  assign pte_cur    = got_q ? pte_q : MemRData;
  assign err_cur    = got_q ? err_q : MemErr;
  assign resp       = (state == WAIT_ACK) && (got_q || MemAck);
  assign ppn_cur    = pte_cur[53:10];
  assign pte_bad    = ~pte_cur[0] | (pte_cur[2] & ~pte_cur[1]);
  assign pte_leaf   = pte_cur[1] | pte_cur[3];
  assign misaligned = ((level_q == 2'd2) && (ppn_cur[17:0] != 18'd0)) ||
                      ((level_q == 2'd1) && (ppn_cur[8:0] != 9'd0));
  assign descend    = ~err_cur & ~pte_bad & ~pte_leaf & (level_q != 2'd0);
  assign vpn_nxt    = (level_q == 2'd2) ? vpn_q[17:9] : vpn_q[8:0];
  assign root_full  = {SATP_PPN, VAdr[38:30], 3'b000};
  assign next_full  = {ppn_cur, vpn_nxt, 3'b000};

`ifdef SVADU_EN
  logic wr_q;
  logic unused_in;
  assign unused_in = ^{VAdr[11:0], pte_cur[63:54], pte_cur[9:4]};
  assign MemWData  = pte_q | 64'h40 | {56'h0, wr_q, 7'h0};
  assign MemWrite  = (state == UPD_REQ);
`else
  logic unused_in;
  assign unused_in = ^{UpdateDA, WriteAccess, VAdr[11:0], pte_cur[63:54], pte_cur[9:4]};
  assign MemWData  = 64'h0;
  assign MemWrite  = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (TLBMiss) state_nxt = REQ;
`ifdef SVADU_EN
        else if (UpdateDA) state_nxt = UPD_REQ;
`endif
      end
      REQ: state_nxt = WAIT_ACK;
      WAIT_ACK: begin
        if (resp) begin
          if (err_cur)       state_nxt = ACCERR;
          else if (pte_bad)  state_nxt = FAULT;
          else if (pte_leaf) state_nxt = misaligned ? FAULT : LEAF;
          else if (!descend) state_nxt = FAULT;
          else               state_nxt = REQ;
        end
      end
      UPD_REQ: if (MemAck) state_nxt = MemErr ? ACCERR : LEAF;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vpn_q   <= '0;
      level_q <= '0;
      adr_q   <= '0;
      pte_q   <= '0;
      got_q   <= 1'b0;
      err_q   <= 1'b0;
`ifdef SVADU_EN
      wr_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (TLBMiss) begin
            vpn_q   <= VAdr[29:12];
            level_q <= 2'd2;
            adr_q   <= root_full[PA_BITS-1:0];
            got_q   <= 1'b0;
            err_q   <= 1'b0;
          end
`ifdef SVADU_EN
          if (TLBMiss || UpdateDA) wr_q <= WriteAccess;
`endif
        end
        REQ: begin
          if (MemAck) begin
            got_q <= 1'b1;
            err_q <= MemErr;
            if (!MemErr) pte_q <= MemRData;
          end
        end
        WAIT_ACK: begin
          if (resp) begin
            got_q <= 1'b0;
            if (!got_q && !MemErr) pte_q <= MemRData;
            if (descend) begin
              level_q <= level_q - 2'd1;
              adr_q   <= next_full[PA_BITS-1:0];
            end
          end
        end
`ifdef SVADU_EN
        UPD_REQ: if (MemAck && !MemErr) pte_q <= MemWData;
`endif
        default: ;
      endcase
    end
  end

  assign MemReq     = (state == REQ) || ((state == WAIT_ACK) && !got_q) || (state == UPD_REQ);
  assign MemAdr     = adr_q;
  assign HPTWStall  = (state != IDLE);
  assign TLBWrite   = (state == LEAF);
  assign PTE        = (state == LEAF) ? pte_q : 64'h0;
  assign PageType   = (state == LEAF) ? level_q : 2'd0;
  assign WalkFault  = (state == FAULT);
  assign WalkAccErr = (state == ACCERR);

endmodule

// File: tb/tb_tlb_miss_walker.sv
// Scoreboard bench for tlb_miss_walker: a level-loop reference walk predicts memory traffic and outcomes.
// A responder serves PTE loads from the predicted access list; a monitor checks every completion pulse.
module tb_tlb_miss_walker;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        TLBMiss = 1'b0, UpdateDA = 1'b0, WriteAccess = 1'b0;
  logic [38:0] VAdr = '0;
  logic [43:0] SATP_PPN = '0;
  logic        MemReq, MemWrite;
  logic [55:0] MemAdr;
  logic [63:0] MemWData;
  logic        MemAck = 1'b0, MemErr = 1'b0;
  logic [63:0] MemRData = '0;
  logic        HPTWStall, TLBWrite, WalkFault, WalkAccErr;
  logic [63:0] PTE;
  logic [1:0]  PageType;

  tlb_miss_walker dut (
    .clk(clk), .reset_n(reset_n), .TLBMiss(TLBMiss), .UpdateDA(UpdateDA),
    .WriteAccess(WriteAccess), .VAdr(VAdr), .SATP_PPN(SATP_PPN),
    .MemReq(MemReq), .MemWrite(MemWrite), .MemAdr(MemAdr), .MemWData(MemWData),
    .MemAck(MemAck), .MemRData(MemRData), .MemErr(MemErr),
    .HPTWStall(HPTWStall), .TLBWrite(TLBWrite), .PTE(PTE), .PageType(PageType),
    .WalkFault(WalkFault), .WalkAccErr(WalkAccErr)
  );

  always #5 clk = ~clk;

  typedef struct {logic [55:0] adr; logic [63:0] data; bit err; bit wr; int d;} acc_t;
  typedef struct {int kind; logic [63:0] pte; logic [1:0] ptype; int cycles;} res_t;

  acc_t acc_q[$];
  res_t res_q[$];
  int n_vec = 0, n_err = 0;
  int cyc = 0, issue_cyc = 0;

  logic [63:0] m_pte = '0;
  logic [55:0] m_adr = '0;
  logic [1:0]  m_level = '0;

  logic [63:0] f_pte [3];
  int f_n = 0, f_d = 0, f_err = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      n_err++;
    end
  endtask

  function automatic logic [63:0] rand_pte(input int level);
    logic [43:0] ppn;
    logic [7:0]  fl;
    int t;
    ppn = {12'($urandom), 32'($urandom)};
    fl  = 8'($urandom) & 8'hF0;
    t   = $urandom_range(0, 7);
    if (t == 0) begin
      fl[3:1] = 3'($urandom);
    end else if (t == 1) begin
      fl[3:0] = {1'($urandom), 3'b101};
    end else if (t <= 4) begin
      fl[3:0] = 4'b0001;
    end else begin
      fl[0] = 1'b1;
      fl[1] = 1'($urandom);
      fl[2] = fl[1] ? 1'($urandom) : 1'b0;
      fl[3] = fl[1] ? 1'($urandom) : 1'b1;
      if ($urandom_range(0, 3) != 0) begin
        if (level == 2) ppn[17:0] = '0;
        if (level == 1) ppn[8:0] = '0;
      end
    end
    return {10'h0, ppn, 2'b00, fl};
  endfunction

  // Reference Sv39 walk: one iteration per level, straight from the translation rules.
  task automatic build_walk(input logic [43:0] satp, input logic [38:0] va, input int dmax);
    int level, kind, k, cycles;
    logic [55:0] adr;
    logic [63:0] p;
    logic [43:0] ppn;
    acc_t a;
    res_t r;
    level = 2; kind = -1; k = 0; cycles = 0;
    adr = {satp, va[38:30], 3'b000};
    while (kind < 0) begin
      a.adr = adr; a.wr = 1'b0;
      if (k < f_n) begin
        a.data = f_pte[k]; a.d = f_d; a.err = (k == f_err);
      end else begin
        a.data = rand_pte(level); a.d = $urandom_range(0, dmax);
        a.err = ($urandom_range(0, 11) == 0);
      end
      acc_q.push_back(a);
      cycles += 1 + ((a.d == 0) ? 1 : a.d);
      m_adr = adr; m_level = 2'(level);
      if (a.err) kind = 2;
      else begin
        p = a.data; m_pte = p; ppn = p[53:10];
        if (!p[0] || (p[2] && !p[1])) kind = 1;
        else if (p[1] || p[3])
          kind = ((level == 2 && ppn[17:0] != 0) || (level == 1 && ppn[8:0] != 0)) ? 1 : 0;
        else if (level == 0) kind = 1;
        else begin
          level--;
          adr = {ppn, va[12+9*level +: 9], 3'b000};
        end
      end
      k++;
    end
    r.kind = kind; r.pte = m_pte; r.ptype = 2'(level); r.cycles = cycles;
    res_q.push_back(r);
  endtask

  task automatic model_reset();
    acc_q.delete(); res_q.delete();
    m_pte = '0; m_adr = '0; m_level = '0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin @(negedge clk); n++; end while (HPTWStall && n < 300);
    if (HPTWStall) begin
      $display("FAIL wait_idle: stall still %0b after %0d cycles, expected 0", HPTWStall, n);
      n_err++; n_vec++;
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (res_q.size() != 0 && n < 300) begin
      @(negedge clk); n++;
      TLBMiss = HPTWStall && !(TLBWrite || WalkFault || WalkAccErr) && ($urandom_range(0, 3) == 0);
      VAdr = {7'($urandom), 32'($urandom)};
    end
    TLBMiss = 1'b0;
    if (res_q.size() != 0) begin
      $display("FAIL walk_timeout: %0d results pending after %0d cycles, expected 0", res_q.size(), n);
      n_err++; n_vec++;
      reset_n = 1'b0; #1; model_reset();
      @(negedge clk); reset_n = 1'b1;
    end
  endtask

  task automatic run_walk(input logic [43:0] satp, input logic [38:0] va, input int dmax, input bit wait_it);
    wait_idle();
    build_walk(satp, va, dmax);
    SATP_PPN = satp; VAdr = va; WriteAccess = 1'($urandom);
    TLBMiss = 1'b1;
    @(posedge clk); #1;
    issue_cyc = cyc; TLBMiss = 1'b0;
    if (wait_it) wait_done();
  endtask

  task automatic upd(input bit wa);
`ifdef SVADU_EN
    acc_t a;
    res_t r;
`else
    bit quiet;
`endif
    wait_idle();
`ifdef SVADU_EN
    a.adr = m_adr; a.wr = 1'b1; a.err = 1'b0; a.d = $urandom_range(0, 2);
    a.data = m_pte | 64'h40 | (wa ? 64'h80 : 64'h0);
    acc_q.push_back(a);
    r.kind = 0; r.pte = a.data; r.ptype = m_level; r.cycles = a.d + 1;
    res_q.push_back(r);
    m_pte = a.data;
    UpdateDA = 1'b1; WriteAccess = wa;
    @(posedge clk); #1;
    issue_cyc = cyc; UpdateDA = 1'b0;
    wait_done();
`else
    UpdateDA = 1'b1; WriteAccess = wa;
    @(posedge clk); #1;
    UpdateDA = 1'b0;
    quiet = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (MemReq || HPTWStall) quiet = 1'b0;
    end
    chk("update_da_ignored", quiet, 1'b1);
`endif
  endtask

  // Memory responder: serves the predicted accesses in order with their planned delay.
  bit   active = 1'b0;
  int   cnt = 0;
  acc_t cur;
  always @(negedge clk) begin
    MemAck = 1'b0; MemErr = 1'b0; MemRData = {$urandom, $urandom};
    if (!reset_n) active = 1'b0;
    else begin
      if (MemReq && !active) begin
        if (acc_q.size() == 0) begin
          $display("FAIL unexpected_req: adr %0h write %0b, no access expected", MemAdr, MemWrite);
          n_err++; n_vec++;
        end else begin
          cur = acc_q.pop_front();
          active = 1'b1; cnt = cur.d;
          chk("mem_adr", MemAdr, cur.adr);
          chk("mem_write", MemWrite, cur.wr);
          if (cur.wr) chk("mem_wdata", MemWData, cur.data);
        end
      end
      if (active) begin
        chk("req_held", MemReq, 1'b1);
        if (cnt == 0) begin
          MemAck = 1'b1; MemErr = cur.err;
          if (!cur.wr) MemRData = cur.data;
          active = 1'b0;
        end else cnt--;
      end
    end
  end

  // Completion monitor.
  bit   chk_idle = 1'b0;
  res_t mr;
  int   kind_act;
  always @(negedge clk) begin
    if (!reset_n) chk_idle = 1'b0;
    else begin
      if (chk_idle) begin
        chk("stall_after_done", HPTWStall, 1'b0);
        chk_idle = 1'b0;
      end
      if (TLBWrite || WalkFault || WalkAccErr) begin
        if ($countones({TLBWrite, WalkFault, WalkAccErr}) != 1) kind_act = 7;
        else kind_act = TLBWrite ? 0 : (WalkFault ? 1 : 2);
        if (res_q.size() == 0) begin
          $display("FAIL unexpected_done: kind %0d, no result expected", kind_act);
          n_err++; n_vec++;
        end else begin
          mr = res_q.pop_front();
          chk("outcome", kind_act, mr.kind);
          chk("latency", cyc - issue_cyc, mr.cycles);
          chk("stall_during", HPTWStall, 1'b1);
          if (mr.kind == 0) begin
            chk("pte", PTE, mr.pte);
            chk("page_type", PageType, mr.ptype);
          end
        end
        chk_idle = 1'b1;
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_memreq", MemReq, 1'b0);
    chk("rst_memwrite", MemWrite, 1'b0);
    chk("rst_memadr", MemAdr, 56'h0);
    chk("rst_stall", HPTWStall, 1'b0);
    chk("rst_tlbwrite", TLBWrite, 1'b0);
    chk("rst_pte", PTE, 64'h0);
    chk("rst_pagetype", PageType, 2'd0);
    chk("rst_fault", WalkFault, 1'b0);
    chk("rst_accerr", WalkAccErr, 1'b0);
    reset_n = 1'b1;

    // 4 KiB walk, same-cycle acks
    f_pte = '{64'h2000_0401, 64'h2000_0801, 64'h2000_04CF};
    f_n = 3; f_d = 0; f_err = -1;
    run_walk(44'h80000, 39'h0040_1000, 0, 1'b1);

    // 2 MiB leaf aligned, then misaligned
    f_pte = '{64'h2000_0401, 64'h2008_00CF, 64'h0};
    f_n = 2; run_walk(44'h80000, 39'h0040_1000, 0, 1'b1);
    f_pte = '{64'h2000_0401, 64'h2008_04CF, 64'h0};
    run_walk(44'h80000, 39'h0040_1000, 0, 1'b1);

    // invalid root PTE
    f_pte = '{64'h0, 64'h0, 64'h0};
    f_n = 1; run_walk(44'h12345, 39'h7F_FFFF_F000, 0, 1'b1);

    // access error on the level-1 load with a delayed ack
    f_pte = '{64'h2000_0401, 64'h2000_0801, 64'h0};
    f_n = 2; f_d = 3; f_err = 1;
    run_walk(44'h80000, 39'h0040_1000, 0, 1'b1);

    // A/D update of a 1 GiB leaf
    f_pte = '{64'h0F, 64'h0, 64'h0};
    f_n = 1; f_d = 0; f_err = -1;
    run_walk(44'h00ABC, 39'h00_0000_0000, 0, 1'b1);
    upd(1'b1);
    upd(1'b0);

    // reset while waiting for an ack
    f_pte = '{64'h2000_0401, 64'h0, 64'h0};
    f_n = 1; f_d = 8;
    run_walk(44'h80000, 39'h0040_1000, 0, 1'b0);
    repeat (3) @(negedge clk);
    chk("mid_walk_req", MemReq, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("reset_drops_req", MemReq, 1'b0);
    chk("reset_drops_stall", HPTWStall, 1'b0);
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    f_pte = '{64'h2000_0401, 64'h2000_0801, 64'h2000_04CF};
    f_n = 3; f_d = 0;
    run_walk(44'h80000, 39'h0040_1000, 0, 1'b1);

    // randomized walks
    f_n = 0; f_err = -1;
    repeat (150)
      run_walk({12'($urandom), 32'($urandom)}, {7'($urandom), 32'($urandom)}, 3, 1'b1);
    upd(1'($urandom));

    wait_idle();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
